// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: console controller in front of the VGA text-mode character
// buffer. It accepts ASCII bytes over a valid/ready handshake, owns the
// cursor and is the only writer of the buffer. It also sequences
// clear-screen, backspace, newline, line wrap and scroll-up. The scan-out
// side keeps its own read port on the buffer and never touches this block.
//
// Buffer address layout is {x, y}, so a column is a contiguous run of
// addresses. All buffer-side outputs are registered.

module vga_text_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int XW   = 7,
    parameter int YW   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [7:0]         key_data,
    output logic               key_ready,
    output logic               mem_we,
    output logic [XW+YW-1:0]   mem_waddr,
    output logic [7:0]         mem_wdata,
    output logic [XW+YW-1:0]   mem_raddr,
    input  logic [7:0]         mem_rdata,
    output logic [XW-1:0]      cur_x,
    output logic [YW-1:0]      cur_y,
    output logic               busy
);

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [YW-1:0] Y_PRE  = YW'(ROWS - 2);

    // ST_COPY issues the reads of the scroll; ST_WIPE blanks the bottom row
    // once the copy pipeline has drained.
    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_COPY,
        ST_WIPE
    } state_t;

    state_t state;

    // Sweep counters shared by CLEAR, COPY and WIPE.
    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;

    // Set once the final write of a sweep has been issued. The following
    // cycle drops to IDLE with mem_we low, so a sweep write never coincides
    // with key_ready.
    logic last_q;

    // Scroll copy pipeline. The read address goes out registered, the buffer
    // answers one cycle later, and the data is captured into a registered
    // write. This takes two stages of destination tracking.
    logic               rd_v1, rd_v2;
    logic [XW+YW-1:0]   dst1, dst2;

    logic               accept;
    logic [XW-1:0]      cur_x_inc, cur_x_dec, cnt_x_inc;
    logic [YW-1:0]      cur_y_inc, cur_y_dec, cnt_y_inc;

    assign accept    = key_valid & key_ready;
    assign cur_x_inc = cur_x + 1'b1;
    assign cur_x_dec = cur_x - 1'b1;
    assign cur_y_inc = cur_y + 1'b1;
    assign cur_y_dec = cur_y - 1'b1;
    assign cnt_x_inc = cnt_x + 1'b1;
    assign cnt_y_inc = cnt_y + 1'b1;

    // Controller FSM: cursor, sweep counters, copy pipeline and all outputs.
    always_ff @(posedge clk) begin
        // NOTE: every register here is state, so all assignments are
        // non-blocking; the defaults at the top are overridden by later
        // assignments in the same cycle.
        if (reset) begin
            // NOTE: the character buffer itself is not reset; CLEAR sweeps it.
            state     <= ST_CLEAR;
            cnt_x     <= '0;
            cnt_y     <= '0;
            last_q    <= 1'b0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            dst1      <= '0;
            dst2      <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_raddr <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            mem_we <= 1'b0;

            // The copy pipeline advances every cycle. Stage 2 turns the
            // returned read data into the write to the row above.
            rd_v1 <= 1'b0;
            rd_v2 <= rd_v1;
            dst2  <= dst1;
            if (rd_v2) begin
                mem_we    <= 1'b1;
                mem_waddr <= dst2;
                mem_wdata <= mem_rdata;
            end

            case (state)
                ST_CLEAR: begin
                    if (last_q) begin
                        last_q    <= 1'b0;
                        state     <= ST_IDLE;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_waddr <= {cnt_x, cnt_y};
                        mem_wdata <= 8'h00;
                        // The column is the outer loop and the row the inner loop.
                        if (cnt_y == Y_LAST) begin
                            cnt_y <= '0;
                            if (cnt_x == X_LAST) begin
                                cnt_x  <= '0;
                                last_q <= 1'b1;
                            end else begin
                                cnt_x <= cnt_x_inc;
                            end
                        end else begin
                            cnt_y <= cnt_y_inc;
                        end
                    end
                end

                ST_IDLE: begin
                    if (accept) begin
                        case (key_data)
                            8'h0A: begin
                                cur_x <= '0;
                                if (cur_y == Y_LAST) begin
                                    state     <= ST_COPY;
                                    key_ready <= 1'b0;
                                    busy      <= 1'b1;
                                    cnt_x     <= '0;
                                    cnt_y     <= '0;
                                end else begin
                                    cur_y <= cur_y_inc;
                                end
                            end

                            8'h08: begin
                                if (cur_x != '0) begin
                                    cur_x     <= cur_x_dec;
                                    mem_we    <= 1'b1;
                                    mem_waddr <= {cur_x_dec, cur_y};
                                    mem_wdata <= 8'h00;
                                end else if (cur_y != '0) begin
                                    cur_x     <= X_LAST;
                                    cur_y     <= cur_y_dec;
                                    mem_we    <= 1'b1;
                                    mem_waddr <= {X_LAST, cur_y_dec};
                                    mem_wdata <= 8'h00;
                                end
                            end

                            8'h0C: begin
                                cur_x     <= '0;
                                cur_y     <= '0;
                                state     <= ST_CLEAR;
                                key_ready <= 1'b0;
                                busy      <= 1'b1;
                                cnt_x     <= '0;
                                cnt_y     <= '0;
                                last_q    <= 1'b0;
                            end

                            default: begin
                                mem_we    <= 1'b1;
                                mem_waddr <= {cur_x, cur_y};
                                mem_wdata <= key_data;
                                if (cur_x == X_LAST) begin
                                    cur_x <= '0;
                                    if (cur_y == Y_LAST) begin
                                        // The character write above goes out
                                        // before the first scroll read is even
                                        // issued, so it is copied up with its row.
                                        state     <= ST_COPY;
                                        key_ready <= 1'b0;
                                        busy      <= 1'b1;
                                        cnt_x     <= '0;
                                        cnt_y     <= '0;
                                    end else begin
                                        cur_y <= cur_y_inc;
                                    end
                                end else begin
                                    cur_x <= cur_x_inc;
                                end
                            end
                        endcase
                    end
                end

                ST_COPY: begin
                    // Read (x, y+1) now; it is written to (x, y) two edges later.
                    // The row is the outer loop and the column the inner loop.
                    // A destination cell has always been read before it is
                    // overwritten.
                    mem_raddr <= {cnt_x, cnt_y_inc};
                    dst1      <= {cnt_x, cnt_y};
                    rd_v1     <= 1'b1;
                    if (cnt_x == X_LAST) begin
                        cnt_x <= '0;
                        if (cnt_y == Y_PRE) begin
                            cnt_y <= '0;
                            state <= ST_WIPE;
                        end else begin
                            cnt_y <= cnt_y_inc;
                        end
                    end else begin
                        cnt_x <= cnt_x_inc;
                    end
                end

                ST_WIPE: begin
                    if (last_q) begin
                        last_q    <= 1'b0;
                        state     <= ST_IDLE;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (!rd_v1 && !rd_v2) begin
                        // Wait for the copy pipeline to drain so its writes
                        // keep the write port to themselves.
                        mem_we    <= 1'b1;
                        mem_waddr <= {cnt_x, Y_LAST};
                        mem_wdata <= 8'h00;
                        if (cnt_x == X_LAST) begin
                            cnt_x  <= '0;
                            last_q <= 1'b1;
                        end else begin
                            cnt_x <= cnt_x_inc;
                        end
                    end
                end

                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: scoreboard bench for the console controller. The
// stimulus tasks keep a model of the screen and the cursor. Each accepted
// key pushes the buffer writes it must cause onto a queue. A monitor pops
// one entry for every mem_we it sees and compares address and data.

module tb_vga_text_ctrl;

    localparam int COLS       = 70;
    localparam int ROWS       = 30;
    localparam int XW         = 7;
    localparam int YW         = 5;
    localparam int AW         = XW + YW;
    localparam int WAIT_LIMIT = 10000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_valid = 1'b0;
    logic [7:0]    key_data = 8'h00;
    logic          key_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          busy;

    always #5 clk = ~clk;

    vga_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    // Character buffer with a registered read port.
    logic [7:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) sram[mem_waddr] <= mem_wdata;
        mem_rdata <= sram[mem_raddr];
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 1'b0;
    logic [7:0] scr [COLS][ROWS];
    int         cx = 0;
    int         cy = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_is_not_ready", int'(busy), int'(!key_ready));
            if (mem_we === 1'b1) begin
                check("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", int'(mem_waddr), int'(e.addr));
                    check("wr_data", int'(mem_wdata), int'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int x, input int y, input logic [7:0] d);
        wr_t w;
        w.addr = {XW'(x), YW'(y)};
        w.data = d;
        exp_q.push_back(w);
        scr[x][y] = d;
    endtask

    task automatic push_clear();
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++)
                push_wr(x, y, 8'h00);
    endtask

    task automatic model_scroll();
        for (int y = 0; y < ROWS - 1; y++)
            for (int x = 0; x < COLS; x++)
                push_wr(x, y, scr[x][y+1]);
        for (int x = 0; x < COLS; x++)
            push_wr(x, ROWS - 1, 8'h00);
        cx = 0;
        cy = ROWS - 1;
    endtask

    task automatic model_key(input logic [7:0] k);
        case (k)
            8'h0A: begin
                cx = 0;
                if (cy == ROWS - 1) model_scroll();
                else cy++;
            end
            8'h08: begin
                if (cx > 0) begin
                    cx--;
                    push_wr(cx, cy, 8'h00);
                end else if (cy > 0) begin
                    cx = COLS - 1;
                    cy--;
                    push_wr(cx, cy, 8'h00);
                end
            end
            8'h0C: begin
                cx = 0;
                cy = 0;
                push_clear();
            end
            default: begin
                push_wr(cx, cy, k);
                if (cx == COLS - 1) begin
                    cx = 0;
                    if (cy == ROWS - 1) model_scroll();
                    else cy++;
                end else begin
                    cx++;
                end
            end
        endcase
    endtask

    // Starts and ends just after a rising edge; returns one edge after accept.
    task automatic send_key(input logic [7:0] k);
        int n;
        n = 0;
        key_valid = 1'b1;
        key_data  = k;
        while (!key_ready && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        check("key_accept", int'(key_ready), 1);
        model_key(k);
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!key_ready && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        check("idle_reached", int'(key_ready), 1);
        check("idle_not_busy", int'(busy), 0);
    endtask

    task automatic check_cur(input string name);
        check({name, "_x"}, int'(cur_x), cx);
        check({name, "_y"}, int'(cur_y), cy);
    endtask

    // One-cycle reset pulse; outstanding expectations are dropped.
    task automatic do_reset();
        reset = 1'b1;
        step();
        exp_q.delete();
        check("rst_we", int'(mem_we), 0);
        check("rst_ready", int'(key_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_cur_x", int'(cur_x), 0);
        check("rst_cur_y", int'(cur_y), 0);
        cx = 0;
        cy = 0;
        push_clear();
        mon_en = 1'b1;
        reset  = 1'b0;
    endtask

    initial begin
        int n;

        // 1: reset, full clear, then ready at (0,0)
        do_reset();
        wait_idle(n);
        check("clear1_drained", exp_q.size(), 0);
        check_cur("t1_cur");

        // 2: back-to-back 'A','B'; each write is visible the cycle after accept
        send_key(8'h41);
        check("a_we", int'(mem_we), 1);
        check("a_addr", int'(mem_waddr), int'({7'd0, 5'd0}));
        send_key(8'h42);
        check("b_we", int'(mem_we), 1);
        check("b_addr", int'(mem_waddr), int'({7'd1, 5'd0}));
        check_cur("t2_cur");
        check("t2_cur_x_const", int'(cur_x), 2);

        // Backspace twice back to the origin, then once more at (0,0): no-op
        send_key(8'h08);
        send_key(8'h08);
        send_key(8'h08);
        check_cur("bs_origin_cur");

        // 3: a full row wraps to the next line, then backspace crosses back
        for (int i = 0; i < COLS; i++) send_key(8'h41);
        check_cur("t3_wrap_cur");
        check("t3_wrap_y", int'(cur_y), 1);
        send_key(8'h08);
        check_cur("t3_bs_cur");
        check("t3_bs_x", int'(cur_x), 69);

        // Tag each row, walk to (5,29), then ENTER on the last row scrolls
        for (int r = 1; r < ROWS; r++) begin
            send_key(8'h0A);
            send_key(8'h30 + 8'(r));
        end
        for (int i = 0; i < 4; i++) send_key(8'h61 + 8'(i));
        check_cur("t4_pre_cur");
        check("t4_pre_x", int'(cur_x), 5);
        send_key(8'h0A);
        check("t4_no_write", int'(mem_we), 0);
        wait_idle(n);
        check("t4_drained", exp_q.size(), 0);
        check_cur("t4_cur");

        // 5: form feed from (10,3)
        send_key(8'h0C);
        wait_idle(n);
        for (int i = 0; i < 3; i++) send_key(8'h0A);
        for (int i = 0; i < 10; i++) send_key(8'h78);
        check_cur("t5_pre_cur");
        send_key(8'h0C);
        check("t5_busy", int'(busy), 1);
        wait_idle(n);
        check("t5_clear_cycles", int'(n >= 2100 && n <= 2102), 1);
        check("t5_drained", exp_q.size(), 0);
        check_cur("t5_cur");

        // Wrap on the last row: the final key write precedes the scroll
        for (int i = 0; i < ROWS - 1; i++) send_key(8'h0A);
        for (int i = 0; i < COLS; i++) send_key(8'h21 + 8'(i % 90));
        wait_idle(n);
        check("wrap_scroll_drained", exp_q.size(), 0);
        check_cur("wrap_scroll_cur");

        // 6: reset in the middle of a scroll restarts a full clear
        send_key(8'h0A);
        for (int i = 0; i < 300; i++) step();
        check("t6_mid_busy", int'(busy), 1);
        do_reset();
        wait_idle(n);
        check_cur("t6_cur");

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
